branch_pc_unit: RTL
===================

// Module: branch_pc_unit
// PURPOSE
//  Program-counter / redirect stage fed by the branch-condition evaluator (its 't' output).
//  Sequences fetch addresses and redirects the PC on taken branches and returns.
//  Flushes the in-flight fetch slots and maintains a link register and a taken-branch counter.
//  Sits between execute (branch resolution) and instruction memory (fetch request).
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  PC_STEP       4              sequential increment (bytes)
//  FLUSH_CYCLES  2              cycles flush is held after a redirect (1..7)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  stall        in   1   hold PC (pipeline back-pressure)
//  br_valid     in   1   branch instruction resolved in execute this cycle
//  t            in   1   branch-taken result from condition evaluator
//  br_pc        in   32  PC of the resolving branch
//  br_target    in   32  branch target address
//  br_link      in   1   branch also writes link register (call)
//  ret_valid    in   1   return: jump to link_addr
//  fetch_ready  in   1   imem accepts pc this cycle
//  pc           out  32  fetch address
//  pc_valid     out  1   pc is a valid fetch request
//  flush        out  1   kill IF/ID contents
//  link_addr    out  32  return address register
//  taken_cnt    out  16  count of taken redirects, saturating
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, pc_valid=0, flush=0, link_addr=0, taken_cnt=0, state=IDLE.
//  Reset mid-flush or mid-stall aborts everything; no pending redirect survives.
//  States: IDLE -> RUN (first edge after rst low; pc_valid=1 from then on).
//  RUN -> FLUSH on redirect. FLUSH -> RUN after FLUSH_CYCLES edges.
//  Redirect condition (RUN only): take = br_valid & t; else ret_valid.
//  - Priority: take > ret_valid > stall > sequential.
//  - take: pc <= {br_target[31:2],2'b00}. If br_link: link_addr <= br_pc + PC_STEP (mod 2^32).
//  - ret: pc <= {link_addr[31:2],2'b00}; link_addr unchanged.
//  - Redirect is accepted even when stall=1 (redirect overrides stall).
//  - Every redirect: taken_cnt += 1, holding at 16'hFFFF.
//  - br_valid & !t: no effect; sequential rules apply.
//  Redirect timing: decision sampled at edge E0.
//  - From E0: pc = target; flush=1 and pc_valid=0.
//  - After edge E0+FLUSH_CYCLES: flush=0 and pc_valid=1 with pc = target (fetch resumes there).
//  - Total bubble = FLUSH_CYCLES cycles.
//  FLUSH state:
//  - br_valid, t, ret_valid, stall and fetch_ready are all ignored; pc is held.
//  - Flush counter is internal, 3 bits.
//  Sequential advance (RUN, no redirect): pc <= pc + PC_STEP iff pc_valid & fetch_ready & !stall.
//  - Otherwise pc holds and pc_valid stays 1 (request held stable until accepted).
//  Wrap-around: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//  Same for link_addr computation.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. rst pulse, fetch_ready=1, no branches ->
//     pc 0,4,8,C on consecutive cycles after IDLE; pc_valid=1; flush=0.
//  2. At pc=0x10: br_valid=1, t=1, br_target=0x103 ->
//     pc=0x100; flush=1 and pc_valid=0 for 2 cycles; then pc_valid=1 at 0x100; taken_cnt=1.
//  3. br_valid=1, t=1, br_link=1, br_pc=0x40, target 0x200; later ret_valid=1 ->
//     link_addr=0x44; pc redirects to 0x44 with 2-cycle flush; taken_cnt=2.
//  4. stall=1 and fetch_ready toggling at pc=0x8 ->
//     pc holds at 0x8, pc_valid=1.
//     Then br_valid=1, t=1 with stall=1 -> redirect still taken.
//  5. Simultaneous br_valid&t (target 0x300) and ret_valid (link 0x44) ->
//     pc=0x300.
//     During FLUSH, issue another br_valid=1, t=1 -> ignored; pc stays 0x300.
//  6. Assert rst during the FLUSH state ->
//     pc=RESET_PC, flush=0, pc_valid=0 immediately (before the next clock edge).
//     Force taken_cnt to 0xFFFF, then redirect -> taken_cnt stays 0xFFFF.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC sequencer with branch/return redirect, flush bubble, link register and taken counter.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        t,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        br_link,
  input  logic        ret_valid,
  input  logic        fetch_ready,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic [31:0] link_addr,
  output logic [15:0] taken_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam logic [31:0] STEP    = 32'(PC_STEP);
  localparam logic [2:0]  FC_LAST = 3'(FLUSH_CYCLES - 1);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, link_addr_q, link_addr_d;
  logic        pc_valid_q, pc_valid_d, flush_q, flush_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        take;
  logic        unused_tgt;
  assign unused_tgt = ^br_target[1:0];
  always_comb begin
    take        = br_valid & t;
    state_d     = state_q;
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    flush_d     = flush_q;
    link_addr_d = link_addr_q;
    taken_cnt_d = taken_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (take | ret_valid) begin
          state_d     = FLUSH;
          pc_d        = take ? {br_target[31:2], 2'b00} : {link_addr_q[31:2], 2'b00};
          link_addr_d = (take & br_link) ? br_pc + STEP : link_addr_q;
          pc_valid_d  = 1'b0;
          flush_d     = 1'b1;
          flush_cnt_d = FC_LAST;
          taken_cnt_d = taken_cnt_q + {15'd0, taken_cnt_q != 16'hFFFF};
        end else if (pc_valid_q & fetch_ready & !stall) begin
          pc_d = pc_q + STEP;
        end
      end
      FLUSH: begin
        // flush_cnt counts down the remaining bubble cycles; all inputs ignored here
        if (flush_cnt_q == 3'd0) begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
          flush_d    = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
      link_addr_q <= 32'd0;
      taken_cnt_q <= 16'd0;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      flush_q     <= flush_d;
      link_addr_q <= link_addr_d;
      taken_cnt_q <= taken_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign flush     = flush_q;
  assign link_addr = link_addr_q;
  assign taken_cnt = taken_cnt_q;
endmodule
